// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - writeback merge of ALU results and buffered load returns onto one register-file write port
//
// Ports:
//   clk, rst                        clock (rising edge), asynchronous active-low reset
//   alu_valid/alu_ready/alu_rd/alu_data   ALU result handshake, ALU has priority
//   ld_valid/ld_ready/ld_rd/ld_data       load return handshake into a DEPTH-entry FIFO
//   regwr/rd/rddata                 registered register-file write port (x0 never written)
//   ld_pending                      bit i set while any buffered load targets register i
//   fifo_count                      current load FIFO occupancy
module writeback_arbiter #(
    parameter int ADDRSIZE   = 5,
    parameter int WORDSIZE   = 64,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      alu_valid,
    output logic                      alu_ready,
    input  logic [ADDRSIZE-1:0]       alu_rd,
    input  logic [WORDSIZE-1:0]       alu_data,
    input  logic                      ld_valid,
    output logic                      ld_ready,
    input  logic [ADDRSIZE-1:0]       ld_rd,
    input  logic [WORDSIZE-1:0]       ld_data,
    output logic                      regwr,
    output logic [ADDRSIZE-1:0]       rd,
    output logic [WORDSIZE-1:0]       rddata,
    output logic [(1<<ADDRSIZE)-1:0]  ld_pending,
    output logic [$clog2(DEPTH):0]    fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    // Load FIFO storage; contents need no reset since validity comes from the pointers.
    logic [ADDRSIZE-1:0] mem_rd_q   [DEPTH];
    logic [ADDRSIZE-1:0] mem_rd_d   [DEPTH];
    logic [WORDSIZE-1:0] mem_data_q [DEPTH];
    logic [WORDSIZE-1:0] mem_data_d [DEPTH];

    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [SW-1:0]       starve_q, starve_d;
    logic                force_q, force_d;
    logic                regwr_q, regwr_d;
    logic [ADDRSIZE-1:0] rd_q, rd_d;
    logic [WORDSIZE-1:0] rddata_q, rddata_d;

    logic                empty, full, enq, grant_alu, grant_fifo;
    logic [ADDRSIZE-1:0] head_rd;
    logic [WORDSIZE-1:0] head_data;
    logic [PW-1:0]       slot_off;

    always_comb begin
        empty      = (count_q == '0);
        full       = (count_q == CW'(DEPTH));
        head_rd    = mem_rd_q[rd_ptr_q];
        head_data  = mem_data_q[rd_ptr_q];

        // A forced cycle always has a non-empty FIFO: only a FIFO grant can drain it.
        grant_fifo = !empty && (force_q || !alu_valid);
        grant_alu  = !force_q && alu_valid;
        alu_ready  = !force_q;
        ld_ready   = !full;
        enq        = ld_valid && !full;

        mem_rd_d   = mem_rd_q;
        mem_data_d = mem_data_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        starve_d   = starve_q;
        force_d    = 1'b0;
        regwr_d    = 1'b0;
        rd_d       = rd_q;
        rddata_d   = rddata_q;

        if (enq) begin
            mem_rd_d[wr_ptr_q]   = ld_rd;
            mem_data_d[wr_ptr_q] = ld_data;
            wr_ptr_d             = wr_ptr_q + PW'(1);
        end
        if (grant_fifo) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (enq && !grant_fifo) begin
            count_d = count_q + CW'(1);
        end else if (!enq && grant_fifo) begin
            count_d = count_q - CW'(1);
        end

        if (grant_alu) begin
            regwr_d  = (alu_rd != '0);
            rd_d     = alu_rd;
            rddata_d = alu_data;
        end else if (grant_fifo) begin
            regwr_d  = (head_rd != '0);
            rd_d     = head_rd;
            rddata_d = head_data;
        end

        // Count consecutive ALU wins over a waiting load; the win that reaches
        // STARVE_MAX arms a one-cycle force instead of storing the count.
        if (empty || grant_fifo) begin
            starve_d = '0;
        end else if (grant_alu) begin
            if (starve_q == SW'(STARVE_MAX - 1)) begin
                force_d  = 1'b1;
                starve_d = '0;
            end else begin
                starve_d = starve_q + SW'(1);
            end
        end
    end

    // Slot i is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        ld_pending = '0;
        slot_off   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_off = PW'(i) - rd_ptr_q;
            if ({1'b0, slot_off} < count_q) begin
                ld_pending[mem_rd_q[i]] = 1'b1;
            end
        end
        ld_pending[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        mem_rd_q   <= mem_rd_d;
        mem_data_q <= mem_data_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            force_q  <= 1'b0;
            regwr_q  <= 1'b0;
            rd_q     <= '0;
            rddata_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            force_q  <= force_d;
            regwr_q  <= regwr_d;
            rd_q     <= rd_d;
            rddata_q <= rddata_d;
        end
    end

    assign regwr      = regwr_q;
    assign rd         = rd_q;
    assign rddata     = rddata_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - randomized and directed bench for writeback_arbiter against a queue-based reference model
module tb_writeback_arbiter;

    localparam int AW    = 5;
    localparam int DW    = 64;
    localparam int DEPTH = 4;
    localparam int SMAX  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_valid;
    logic          alu_ready;
    logic [AW-1:0] alu_rd;
    logic [DW-1:0] alu_data;
    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_rd;
    logic [DW-1:0] ld_data;
    logic          regwr;
    logic [AW-1:0] rd;
    logic [DW-1:0] rddata;
    logic [31:0]   ld_pending;
    logic [2:0]    fifo_count;

    writeback_arbiter #(
        .ADDRSIZE(AW), .WORDSIZE(DW), .DEPTH(DEPTH), .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .regwr(regwr), .rd(rd), .rddata(rddata),
        .ld_pending(ld_pending), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_stall = 0;

    // Reference model: load FIFO as queues, write port as plain variables.
    logic [AW-1:0] mq_rd[$];
    logic [DW-1:0] mq_data[$];
    int            m_lost;
    bit            m_force;
    bit            m_regwr;
    logic [AW-1:0] m_rd;
    logic [DW-1:0] m_rddata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        mq_rd.delete();
        mq_data.delete();
        m_lost   = 0;
        m_force  = 0;
        m_regwr  = 0;
        m_rd     = '0;
        m_rddata = '0;
    endfunction

    function automatic logic [31:0] model_pending();
        logic [31:0] m = '0;
        foreach (mq_rd[i]) m[mq_rd[i]] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    task automatic check_outputs();
        chk("regwr", regwr, m_regwr);
        chk("rd", rd, m_rd);
        chk("rddata", rddata, m_rddata);
        chk("fifo_count", fifo_count, mq_rd.size());
        chk("ld_pending", ld_pending, model_pending());
    endtask

    // Called at a falling edge: check state, drive inputs, check handshake readies,
    // advance the model across the coming rising edge, return at the next falling edge.
    task automatic cycle(input bit av, input logic [AW-1:0] ard, input logic [DW-1:0] adata,
                         input bit lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ldata);
        bit nonempty, full, nf;
        int g;
        check_outputs();
        alu_valid = av; alu_rd = ard; alu_data = adata;
        ld_valid  = lv; ld_rd  = lrd; ld_data  = ldata;
        #1;
        chk("alu_ready", alu_ready, !m_force);
        chk("ld_ready", ld_ready, mq_rd.size() < DEPTH);
        if (alu_ready === 1'b0) n_stall++;

        nonempty = mq_rd.size() > 0;
        full     = mq_rd.size() == DEPTH;
        if (m_force)       g = 2;
        else if (av)       g = 1;
        else if (nonempty) g = 2;
        else               g = 0;
        nf = 0;
        if (g == 1) begin
            m_rd = ard; m_rddata = adata; m_regwr = (ard != 0);
        end else if (g == 2) begin
            m_rd = mq_rd.pop_front(); m_rddata = mq_data.pop_front(); m_regwr = (m_rd != 0);
        end else begin
            m_regwr = 0;
        end
        if (!nonempty || g == 2) begin
            m_lost = 0;
        end else begin
            m_lost++;
            if (m_lost == SMAX) begin
                nf = 1;
                m_lost = 0;
            end
        end
        m_force = nf;
        if (lv && !full) begin
            mq_rd.push_back(lrd);
            mq_data.push_back(ldata);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        cycle(0, '0, '0, 0, '0, '0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_regwr"}, regwr, 0);
        chk({tag, "_rd"}, rd, 0);
        chk({tag, "_rddata"}, rddata, 0);
        chk({tag, "_count"}, fifo_count, 0);
        chk({tag, "_pending"}, ld_pending, 0);
        chk({tag, "_ld_ready"}, ld_ready, 1);
        chk({tag, "_alu_ready"}, alu_ready, 1);
    endtask

    initial begin
        int alu_pct;
        rst = 1'b0;
        alu_valid = 0; alu_rd = '0; alu_data = '0;
        ld_valid  = 0; ld_rd  = '0; ld_data  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_values("rst0");
        rst = 1'b1;

        // ALU only
        cycle(1, 5'd5, 64'h1234, 0, '0, '0);
        chk("alu_wr_regwr", regwr, 1);
        chk("alu_wr_rd", rd, 5);
        chk("alu_wr_data", rddata, 64'h1234);
        idle();
        chk("alu_wr_after", regwr, 0);

        // Single load into an empty FIFO
        cycle(0, '0, '0, 1, 5'd7, 64'hDEAD_BEEF);
        chk("ld_pend7", ld_pending[7], 1);
        chk("ld_no_bypass", regwr, 0);
        idle();
        chk("ld_wr_regwr", regwr, 1);
        chk("ld_wr_rd", rd, 7);
        chk("ld_wr_data", rddata, 64'hDEAD_BEEF);
        chk("ld_pend7_clr", ld_pending[7], 0);

        // x0 from both ports
        cycle(1, 5'd0, 64'hAA, 1, 5'd0, 64'hBB);
        chk("x0_alu_regwr", regwr, 0);
        chk("x0_ld_queued", fifo_count, 1);
        idle();
        chk("x0_ld_regwr", regwr, 0);
        chk("x0_ld_drained", fifo_count, 0);

        // Fill the FIFO behind a busy ALU, then let starvation drain it
        n_stall = 0;
        for (int i = 0; i < 4; i++)
            cycle(1, AW'(10 + i), {$urandom, $urandom}, 1, AW'(20 + i), {$urandom, $urandom});
        chk("full_count", fifo_count, 4);
        chk("full_ready", ld_ready, 0);
        cycle(1, 5'd14, {$urandom, $urandom}, 1, 5'd25, {$urandom, $urandom});
        chk("full_reject", fifo_count, 4);
        chk("full_no_pend25", ld_pending[25], 0);
        for (int i = 0; i < 50; i++)
            cycle(1, AW'($urandom_range(1, 31)), {$urandom, $urandom}, 0, '0, '0);
        chk("starve_forces", n_stall, 4);
        chk("starve_drained", fifo_count, 0);

        // Asynchronous reset mid-stream with three buffered loads
        for (int i = 0; i < 3; i++)
            cycle(1, AW'(1 + i), {$urandom, $urandom}, 1, AW'(3 + i), {$urandom, $urandom});
        chk("pre_rst_count", fifo_count, 3);
        alu_valid = 0; ld_valid = 0;
        #2 rst = 1'b0;
        #1 check_reset_values("rst_mid");
        model_reset();
        @(negedge clk);
        rst = 1'b1;

        // Randomized traffic at several ALU loads
        for (int p = 0; p < 3; p++) begin
            alu_pct = (p == 0) ? 20 : (p == 1) ? 50 : 95;
            for (int i = 0; i < 600; i++)
                cycle($urandom_range(0, 99) < alu_pct, AW'($urandom_range(0, 31)), {$urandom, $urandom},
                      $urandom_range(0, 99) < 60, AW'($urandom_range(0, 31)), {$urandom, $urandom});
        end
        for (int i = 0; i < 6; i++) idle();
        check_outputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
